acc_peak_count: RTL

ACC_PEAK_COUNT -- requirements
Module: acc_peak_count

---
 rtl/acc_peak_count.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/acc_peak_count.sv
// acc_peak_count
//
// Consumes an accumulator vote stream, one frame at a time, and reports two
// result words per frame: the number of peaks (maximal runs of consecutive
// votes >= threshold) followed by the largest vote seen in the frame.
//
// Ports:
//   aclk             clock, rising edge
//   areset           asynchronous active-high reset
//   threshold        minimum vote counted as hot (latched on first beat)
//   s00_axis_tdata   incoming vote, unsigned
//   s00_axis_tvalid  incoming beat valid
//   s00_axis_tlast   last vote of the frame
//   s00_axis_tready  block accepts a beat (high only while collecting)
//   m00_axis_tdata   result word: peak count, then frame maximum
//   m00_axis_tvalid  result word valid
//   m00_axis_tlast   high on the frame-maximum word
//   m00_axis_tready  downstream accepts a result word
module acc_peak_count #(
    parameter int S00_AXIS_TDATA_WIDTH = 32,
    parameter int M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [31:0]                     threshold,
    input  logic [S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                            s00_axis_tvalid,
    input  logic                            s00_axis_tlast,
    output logic                            s00_axis_tready,
    output logic [M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                            m00_axis_tvalid,
    output logic                            m00_axis_tlast,
    input  logic                            m00_axis_tready
);

    // Compare width wide enough for both the vote and the 32-bit threshold.
    localparam int CMP_W = (S00_AXIS_TDATA_WIDTH > 32) ? S00_AXIS_TDATA_WIDTH : 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EMIT_CNT = 2'd1,
        EMIT_MAX = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]                     count;
    logic [S00_AXIS_TDATA_WIDTH-1:0] max_val;
    logic [31:0]                     thr_latched;
    logic                            in_run;      // previous beat of this frame was hot
    logic                            frame_open;  // at least one beat of this frame accepted

    logic              accept;
    logic [31:0]       thr_eff;
    logic [CMP_W-1:0]  data_ext;
    logic [CMP_W-1:0]  thr_ext;
    logic              hot;
    logic              emit_done;

    // Saturating increment: the peak count sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        if (c == 32'hFFFF_FFFF) begin
            return c;
        end
        return c + 32'd1;
    endfunction

    assign accept    = s00_axis_tvalid && s00_axis_tready;
    assign emit_done = (state == EMIT_MAX) && m00_axis_tready;

    // The first beat of a frame sees the live threshold, because the latched
    // copy is only written on that same edge.
    assign thr_eff  = frame_open ? thr_latched : threshold;
    assign data_ext = CMP_W'(s00_axis_tdata);
    assign thr_ext  = CMP_W'(thr_eff);
    assign hot      = (data_ext >= thr_ext);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN:      if (accept && s00_axis_tlast) state_next = EMIT_CNT;
            EMIT_CNT: if (m00_axis_tready)          state_next = EMIT_MAX;
            EMIT_MAX: if (m00_axis_tready)          state_next = RUN;
            default:                                state_next = RUN;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count       <= '0;
            max_val     <= '0;
            thr_latched <= '0;
            in_run      <= 1'b0;
            frame_open  <= 1'b0;
        end else if (emit_done) begin
            count       <= '0;
            max_val     <= '0;
            in_run      <= 1'b0;
            frame_open  <= 1'b0;
        end else if (accept) begin
            if (!frame_open) begin
                thr_latched <= threshold;
            end
            frame_open <= !s00_axis_tlast;
            if (hot && !in_run) begin
                count <= sat_inc(count);
            end
            // A run never carries past the frame's last beat.
            in_run <= hot && !s00_axis_tlast;
            if (s00_axis_tdata > max_val) begin
                max_val <= s00_axis_tdata;
            end
        end
    end

    // Outputs decode directly from registered state; count and maximum are
    // frozen outside RUN, so the result word is stable while stalled.
    always_comb begin
        s00_axis_tready = 1'b0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        m00_axis_tdata  = '0;
        unique case (state)
            RUN: begin
                s00_axis_tready = 1'b1;
            end
            EMIT_CNT: begin
                m00_axis_tvalid = 1'b1;
                m00_axis_tdata  = M00_AXIS_TDATA_WIDTH'(count);
            end
            EMIT_MAX: begin
                m00_axis_tvalid = 1'b1;
                m00_axis_tlast  = 1'b1;
                m00_axis_tdata  = M00_AXIS_TDATA_WIDTH'(max_val);
            end
            default: begin
                s00_axis_tready = 1'b0;
            end
        endcase
    end

endmodule
